// File: rtl/fpadd_wb_stage.sv
// ---------------------------------------------------------------------------
// fpadd_wb_stage
//
// Registered writeback stage sitting directly behind the combinational fpadd
// unit. Each fpadd result is captured together with its exception flags, its
// denormal indication and its destination tag. Entries are held in a
// two-entry skid buffer (head + skid). Because of the second entry, in_ready
// can come straight from a flop. The stage also keeps the architectural
// sticky exception flags and a saturating count of denormal results. Both
// are updated only when an entry commits to the register-file write port.
//
// Parameters
//   WIDTH  result width
//   TAG_W  destination-register tag width
//   CNT_W  width of the saturating denormal-result counter
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous, active-low reset
//   in_valid    fpadd output valid
//   in_ready    stage can accept (registered)
//   in_result   fpadd result
//   in_flags    fpadd flags {NV, DZ, OF, UF, NX}
//   in_denorm   fpadd denormal-result indication
//   in_tag      destination tag travelling with the operation
//   out_valid   head entry valid
//   out_ready   register file accepts the head entry
//   out_result  head entry result
//   out_flags   head entry flags
//   out_denorm  head entry denorm bit
//   out_tag     head entry tag
//   fflags_clr  clear the sticky flags (CSR write)
//   fflags      sticky OR of the flags of all committed entries
//   denorm_cnt  saturating count of committed entries with denorm set
// ---------------------------------------------------------------------------
module fpadd_wb_stage #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [4:0]       in_flags,
  input  logic             in_denorm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_flags,
  output logic             out_denorm,
  output logic [TAG_W-1:0] out_tag,
  input  logic             fflags_clr,
  output logic [4:0]       fflags,
  output logic [CNT_W-1:0] denorm_cnt
);

  // Buffer occupancy states
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             in_ready_q;

  logic [WIDTH-1:0] head_result_q;
  logic [4:0]       head_flags_q;
  logic             head_denorm_q;
  logic [TAG_W-1:0] head_tag_q;

  logic [WIDTH-1:0] skid_result_q;
  logic [4:0]       skid_flags_q;
  logic             skid_denorm_q;
  logic [TAG_W-1:0] skid_tag_q;

  logic [4:0]       fflags_q;
  logic [4:0]       fflags_d;
  logic [CNT_W-1:0] denorm_cnt_q;

  logic             head_valid;
  logic             accept;
  logic             commit;
  logic             load_head_in;
  logic             load_head_skid;
  logic             load_skid;
  logic             cnt_inc;

  // The head holds a valid entry in both ONE and TWO; any undefined
  // encoding is treated as empty and is steered back to EMPTY below.
  assign head_valid = (state_q == S_ONE) || (state_q == S_TWO);
  assign accept     = in_valid & in_ready_q;
  assign commit     = head_valid & out_ready;

  // Next-state and load-enable decode. A simultaneous accept and commit in
  // ONE replaces the head in place, so the skid is only used when the
  // register file stalls.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d      = S_ONE;
          load_head_in = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && commit) begin
          load_head_in = 1'b1;
        end else if (accept) begin
          state_d   = S_TWO;
          load_skid = 1'b1;
        end else if (commit) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (commit) begin
          state_d        = S_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // Occupancy state. in_ready is recomputed from the next state, so it is a
  // plain flop output and never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_TWO);
    end
  end

  // Head payload: filled from the input, or from the skid when the buffer
  // drains out of TWO. The payload is always captured as one unit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_result_q <= '0;
      head_flags_q  <= '0;
      head_denorm_q <= 1'b0;
      head_tag_q    <= '0;
    end else if (load_head_in) begin
      head_result_q <= in_result;
      head_flags_q  <= in_flags;
      head_denorm_q <= in_denorm;
      head_tag_q    <= in_tag;
    end else if (load_head_skid) begin
      head_result_q <= skid_result_q;
      head_flags_q  <= skid_flags_q;
      head_denorm_q <= skid_denorm_q;
      head_tag_q    <= skid_tag_q;
    end
  end

  // Skid payload: only written when an entry arrives while the head is
  // stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_result_q <= '0;
      skid_flags_q  <= '0;
      skid_denorm_q <= 1'b0;
      skid_tag_q    <= '0;
    end else if (load_skid) begin
      skid_result_q <= in_result;
      skid_flags_q  <= in_flags;
      skid_denorm_q <= in_denorm;
      skid_tag_q    <= in_tag;
    end
  end

  // The clear applies to the old value only, so flags committing in the
  // same cycle as a CSR clear are kept.
  assign fflags_d = (fflags_clr ? 5'b0 : fflags_q) | (commit ? head_flags_q : 5'b0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  // The denormal counter holds at all-ones instead of wrapping. It is not
  // tied to the CSR flag clear.
  assign cnt_inc = commit & head_denorm_q & (denorm_cnt_q != {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      denorm_cnt_q <= '0;
    end else if (cnt_inc) begin
      denorm_cnt_q <= denorm_cnt_q + CNT_W'(1);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = head_valid;
  assign out_result = head_result_q;
  assign out_flags  = head_flags_q;
  assign out_denorm = head_denorm_q;
  assign out_tag    = head_tag_q;
  assign fflags     = fflags_q;
  assign denorm_cnt = denorm_cnt_q;

endmodule

// File: tb/tb_fpadd_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_fpadd_wb_stage
//
// Self-checking bench for fpadd_wb_stage, built with CNT_W=2 so that the
// denormal counter saturates quickly. Accepted entries are pushed into an
// expected-value queue. A monitor pops one entry on every commit, compares
// the payload, and tracks a reference model of fflags and denorm_cnt. The
// main sequence adds directed checks for latency, backpressure, streaming
// throughput, the clear/commit collision and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_fpadd_wb_stage;

  localparam int WIDTH = 64;
  localparam int TAG_W = 5;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = 3;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [4:0]       f;
    logic             d;
    logic [TAG_W-1:0] t;
  } ent_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [4:0]       in_flags;
  logic             in_denorm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [4:0]       out_flags;
  logic             out_denorm;
  logic [TAG_W-1:0] out_tag;
  logic             fflags_clr;
  logic [4:0]       fflags;
  logic [CNT_W-1:0] denorm_cnt;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   commit_cnt = 0;
  ent_t sb[$];
  logic [4:0] m_fflags = '0;
  int   m_cnt = 0;

  fpadd_wb_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_result(in_result),
    .in_flags(in_flags),
    .in_denorm(in_denorm),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_flags(out_flags),
    .out_denorm(out_denorm),
    .out_tag(out_tag),
    .fflags_clr(fflags_clr),
    .fflags(fflags),
    .denorm_cnt(denorm_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one entry and hold it until the stage takes it; returns 1ns after
  // the accepting edge with in_valid still asserted.
  task automatic applyStimulus(input logic [63:0] r, input logic [4:0] f, input logic d,
                               input logic [4:0] t);
    int n;
    in_valid  = 1'b1;
    in_result = r;
    in_flags  = f;
    in_denorm = d;
    in_tag    = t;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL send_timeout actual=in_ready_low required=accept_within_200");
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard push: the entry present at the falling edge is accepted at
  // the following rising edge.
  always @(negedge clk) begin
    if (reset && in_valid && in_ready) begin
      sb.push_back('{r: in_result, f: in_flags, d: in_denorm, t: in_tag});
    end
  end

  // Monitor: compares commits against the queue and tracks the sticky flag
  // and denormal counter reference model.
  always @(negedge clk) begin
    ent_t e;
    logic cmt;
    logic [4:0] cf;
    logic cd;
    if (!reset) begin
      sb.delete();
      m_fflags = '0;
      m_cnt = 0;
    end else begin
      checkOutput("fflags_track", 64'(fflags), 64'(m_fflags));
      checkOutput("denorm_cnt_track", 64'(denorm_cnt), 64'(m_cnt));
      cmt = out_valid && out_ready;
      cf = '0;
      cd = 1'b0;
      if (cmt) begin
        commit_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_commit actual=tag_%0d required=no_commit", out_tag);
        end else begin
          e = sb.pop_front();
          checkOutput("commit_result", out_result, e.r);
          checkOutput("commit_flags", 64'(out_flags), 64'(e.f));
          checkOutput("commit_denorm", 64'(out_denorm), 64'(e.d));
          checkOutput("commit_tag", 64'(out_tag), 64'(e.t));
          cf = e.f;
          cd = e.d;
        end
      end
      m_fflags = (fflags_clr ? 5'b0 : m_fflags) | cf;
      if (cd && m_cnt < CNT_MAX) m_cnt++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int c0;
    int exp_cnt [5] = '{1, 2, 3, 3, 3};

    reset      = 1'b0;
    in_valid   = 1'b0;
    in_result  = '0;
    in_flags   = '0;
    in_denorm  = 1'b0;
    in_tag     = '0;
    out_ready  = 1'b1;
    fflags_clr = 1'b0;

    // Values held while reset is asserted
    #7;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_fflags", 64'(fflags), 64'd0);
    checkOutput("rst_denorm_cnt", 64'(denorm_cnt), 64'd0);
    checkOutput("rst_out_result", out_result, 64'd0);
    #16;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single entry: visible one cycle after acceptance, then commits
    applyStimulus(64'h4000000000000000, 5'b00001, 1'b0, 5'd3);
    checkOutput("single_out_valid", 64'(out_valid), 64'd1);
    checkOutput("single_result", out_result, 64'h4000000000000000);
    checkOutput("single_flags", 64'(out_flags), 64'd1);
    checkOutput("single_tag", 64'(out_tag), 64'd3);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("single_fflags", 64'(fflags), 64'd1);
    checkOutput("single_drained", 64'(out_valid), 64'd0);

    // Backpressure fill: A and B taken, C held until the head drains
    out_ready = 1'b0;
    applyStimulus(64'hAAAA000000000001, 5'b00000, 1'b0, 5'd10);
    applyStimulus(64'hBBBB000000000002, 5'b00000, 1'b0, 5'd11);
    checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
    in_result = 64'hCCCC000000000003;
    in_flags  = 5'b00000;
    in_denorm = 1'b0;
    in_tag    = 5'd12;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_hold_tag", 64'(out_tag), 64'd10);
    checkOutput("bp_hold_result", out_result, 64'hAAAA000000000001);
    out_ready = 1'b1;
    applyStimulus(64'hCCCC000000000003, 5'b00000, 1'b0, 5'd12);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_drained", 64'(sb.size()), 64'd0);

    // Clear/commit collision
    fflags_clr = 1'b1;
    @(posedge clk);
    #1;
    fflags_clr = 1'b0;
    checkOutput("clr_only", 64'(fflags), 64'd0);
    applyStimulus(64'h1, 5'b10000, 1'b0, 5'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("nv_sticky", 64'(fflags), 64'b10000);
    out_ready = 1'b0;
    applyStimulus(64'h2, 5'b00100, 1'b0, 5'd2);
    in_valid = 1'b0;
    fflags_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    fflags_clr = 1'b0;
    checkOutput("clr_commit_collision", 64'(fflags), 64'b00100);

    // Denormal counter saturation at 3
    for (int k = 0; k < 5; k++) begin
      applyStimulus(64'h0000000000000001 + 64'(k), 5'b00011, 1'b1, 5'(k));
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput($sformatf("denorm_cnt_%0d", k), 64'(denorm_cnt), 64'(exp_cnt[k]));
    end
    fflags_clr = 1'b1;
    @(posedge clk);
    #1;
    fflags_clr = 1'b0;
    checkOutput("denorm_cnt_after_clr", 64'(denorm_cnt), 64'd3);
    checkOutput("fflags_after_clr", 64'(fflags), 64'd0);

    // Streaming: 100 back-to-back entries, one per cycle
    t0 = cyc;
    c0 = commit_cnt;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(64'h3FF0000000000000 + 64'(i), 5'(i % 32), i[0], 5'(i));
    end
    in_valid = 1'b0;
    checkOutput("stream_cycles", 64'(cyc - t0), 64'd100);
    @(posedge clk);
    #1;
    checkOutput("stream_commits", 64'(commit_cnt - c0), 64'd100);
    checkOutput("stream_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset while the buffer is full
    out_ready = 1'b0;
    applyStimulus(64'h5555, 5'b01000, 1'b1, 5'd20);
    applyStimulus(64'h6666, 5'b00010, 1'b1, 5'd21);
    in_valid = 1'b0;
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_in_ready", 64'(in_ready), 64'd1);
    checkOutput("async_fflags", 64'(fflags), 64'd0);
    checkOutput("async_denorm_cnt", 64'(denorm_cnt), 64'd0);
    checkOutput("async_out_result", out_result, 64'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(64'h7777, 5'b00001, 1'b1, 5'd22);
    in_valid = 1'b0;
    checkOutput("post_rst_valid", 64'(out_valid), 64'd1);
    checkOutput("post_rst_tag", 64'(out_tag), 64'd22);
    @(posedge clk);
    #1;
    checkOutput("post_rst_fflags", 64'(fflags), 64'd1);
    checkOutput("post_rst_denorm_cnt", 64'(denorm_cnt), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("final_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
